// File: rtl/lut_sweep_pkg.sv
// Shared types and sizing helpers for the LUT sweep engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lut_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Number of rows in a truth table of n_in inputs.
    function automatic int rows_of(input int n_in);
        return 1 << n_in;
    endfunction

    // Channel index width; never collapses to zero bits for a single table.
    function automatic int ch_w_of(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/lut_bank.sv
// Register bank of N_CH truth tables with a combinational (ch,row) read mux.
// Latency: write visible on the next cycle; read is combinational.
// Backpressure: none; writes to channels >= N_CH are dropped.
// Ports: we/ch/data = write port; rd_ch/rd_row -> rd_bit = table[rd_ch][rd_row].
module lut_bank
    import lut_sweep_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int N_CH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ch_w_of(N_CH)-1:0]   ch,
    input  logic [rows_of(N_IN)-1:0]   data,
    input  logic [ch_w_of(N_CH)-1:0]   rd_ch,
    input  logic [N_IN-1:0]            rd_row,
    output logic                       rd_bit
);
    localparam int ROWS = rows_of(N_IN);
    localparam int CH_W = ch_w_of(N_CH);

    logic [ROWS-1:0] tbl_q [N_CH];
    logic [ROWS-1:0] tbl_d [N_CH];

    // Matching against each legal channel index drops out-of-range writes
    // without ever indexing past the array.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            tbl_d[i] = tbl_q[i];
            if (we && (ch == CH_W'(i))) begin
                tbl_d[i] = data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    // Generalised 2**N_IN:1 mux per channel, then channel select.
    always_comb begin
        rd_bit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_bit = tbl_q[i][rd_row];
            end
        end
    end

endmodule

// File: rtl/lut_sweep_engine.sv
// Sweeps all input combinations of a selected truth table, one registered row per step.
// Latency: row r at E0+1+r*STEP_CYCLES after start edge E0; done STEP_CYCLES after last row.
// Backpressure: none; start is only sampled in IDLE, table writes dropped while busy.
// Ports: cfg_we/cfg_ch/cfg_data write tables; start/ch_sel launch a sweep;
//        busy/row_valid/row_in/row_out/done/result report it.
// Optional: LUT_SWEEP_CHECK_EN adds exp_vec compare (mismatch/err_count/first_err_row).
module lut_sweep_engine
    import lut_sweep_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int N_CH        = 2,
    parameter int STEP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [ch_w_of(N_CH)-1:0]   cfg_ch,
    input  logic [rows_of(N_IN)-1:0]   cfg_data,
    input  logic                       start,
    input  logic [ch_w_of(N_CH)-1:0]   ch_sel,
    output logic                       busy,
    output logic                       row_valid,
    output logic [N_IN-1:0]            row_in,
    output logic                       row_out,
    output logic                       done,
    output logic [rows_of(N_IN)-1:0]   result
`ifdef LUT_SWEEP_CHECK_EN
    ,
    input  logic [rows_of(N_IN)-1:0]   exp_vec,
    output logic                       mismatch,
    output logic [N_IN:0]              err_count,
    output logic [N_IN-1:0]            first_err_row
`endif
);
    localparam int ROWS = rows_of(N_IN);
    localparam int CH_W = ch_w_of(N_CH);
    localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_CYCLES - 1);
    localparam logic [N_IN:0]   ROWS_L    = (N_IN + 1)'(ROWS);

    sweep_state_t     state_q, state_d;
    logic [SC_W-1:0]  step_q, step_d;
    logic [N_IN:0]    row_q, row_d;     // one extra bit: reaching ROWS ends the pass
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             row_vld_q, row_vld_d;
    logic [N_IN-1:0]  row_in_q, row_in_d;
    logic             row_out_q, row_out_d;
    logic             done_q, done_d;
    logic [ROWS-1:0]  result_q, result_d;

    logic             lut_bit;
    logic             ch_sel_ok;
    logic             start_acc;
    logic             emit;
    logic [N_IN-1:0]  row_idx;

    assign row_idx = row_q[N_IN-1:0];

    // Tables are write-protected for the whole sweep, including the DONE cycle.
    lut_bank #(.N_IN(N_IN), .N_CH(N_CH)) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (cfg_we && (state_q == IDLE)),
        .ch     (cfg_ch),
        .data   (cfg_data),
        .rd_ch  (ch_q),
        .rd_row (row_idx),
        .rd_bit (lut_bit)
    );

    always_comb begin
        ch_sel_ok = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                ch_sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        row_d     = row_q;
        ch_d      = ch_q;
        row_vld_d = 1'b0;
        row_in_d  = row_in_q;
        row_out_d = row_out_q;
        done_d    = 1'b0;
        result_d  = result_q;
        start_acc = 1'b0;
        emit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && ch_sel_ok) begin
                    start_acc = 1'b1;
                    state_d   = RUN;
                    ch_d      = ch_sel;
                    result_d  = '0;
                    row_d     = '0;
                    step_d    = '0;
                end
            end
            RUN: begin
                // A step slot past the last row raises done, so done trails
                // the last row by exactly one step period.
                if (step_q == '0) begin
                    if (row_q == ROWS_L) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        emit              = 1'b1;
                        row_vld_d         = 1'b1;
                        row_in_d          = row_idx;
                        row_out_d         = lut_bit;
                        result_d[row_idx] = lut_bit;
                        row_d             = row_q + (N_IN + 1)'(1);
                    end
                end
                step_d = (step_q == STEP_LAST) ? '0 : step_q + SC_W'(1);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            row_q     <= '0;
            ch_q      <= '0;
            row_vld_q <= 1'b0;
            row_in_q  <= '0;
            row_out_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            row_vld_q <= row_vld_d;
            row_in_q  <= row_in_d;
            row_out_q <= row_out_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign row_valid = row_vld_q;
    assign row_in    = row_in_q;
    assign row_out   = row_out_q;
    assign done      = done_q;
    assign result    = result_q;

`ifdef LUT_SWEEP_CHECK_EN
    logic [ROWS-1:0] exp_q, exp_d;
    logic            mis_q, mis_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fer_q, fer_d;

    always_comb begin
        exp_d = exp_q;
        mis_d = mis_q;
        err_d = err_q;
        fer_d = fer_q;
        if (start_acc) begin
            exp_d = exp_vec;
            mis_d = 1'b0;
            err_d = '0;
            fer_d = '0;
        end else if (emit && (lut_bit != exp_q[row_idx])) begin
            if (err_q != ROWS_L) begin
                err_d = err_q + (N_IN + 1)'(1);
            end
            // Only the first miscompare of a sweep records its row.
            if (!mis_q) begin
                fer_d = row_idx;
            end
            mis_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            mis_q <= 1'b0;
            err_q <= '0;
            fer_q <= '0;
        end else begin
            exp_q <= exp_d;
            mis_q <= mis_d;
            err_q <= err_d;
            fer_q <= fer_d;
        end
    end

    assign mismatch      = mis_q;
    assign err_count     = err_q;
    assign first_err_row = fer_q;
`endif

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Directed bench for lut_sweep_engine: default instance plus a 3-channel, 3-cycle-step instance.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lut_sweep_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_ch = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       start = 1'b0;
    logic       ch_sel = 1'b0;
    logic       busy, row_valid, row_out, done;
    logic [2:0] row_in;
    logic [7:0] result;

    logic       cfg_we3 = 1'b0;
    logic [1:0] cfg_ch3 = 2'd0;
    logic       start3 = 1'b0;
    logic [1:0] ch_sel3 = 2'd0;
    logic       busy3, row_valid3, row_out3, done3;
    logic [2:0] row_in3;
    logic [7:0] result3;

    logic [7:0] exp_vec = 8'h00;
`ifdef LUT_SWEEP_CHECK_EN
    logic       mismatch, mismatch3;
    logic [3:0] err_count, err_count3;
    logic [2:0] first_err_row, first_err_row3;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lut_sweep_engine #(.N_IN(3), .N_CH(2), .STEP_CYCLES(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_data  (cfg_data),
        .start     (start),
        .ch_sel    (ch_sel),
        .busy      (busy),
        .row_valid (row_valid),
        .row_in    (row_in),
        .row_out   (row_out),
        .done      (done),
        .result    (result)
`ifdef LUT_SWEEP_CHECK_EN
        ,
        .exp_vec       (exp_vec),
        .mismatch      (mismatch),
        .err_count     (err_count),
        .first_err_row (first_err_row)
`endif
    );

    lut_sweep_engine #(.N_IN(3), .N_CH(3), .STEP_CYCLES(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we3),
        .cfg_ch    (cfg_ch3),
        .cfg_data  (cfg_data),
        .start     (start3),
        .ch_sel    (ch_sel3),
        .busy      (busy3),
        .row_valid (row_valid3),
        .row_in    (row_in3),
        .row_out   (row_out3),
        .done      (done3),
        .result    (result3)
`ifdef LUT_SWEEP_CHECK_EN
        ,
        .exp_vec       (exp_vec),
        .mismatch      (mismatch3),
        .err_count     (err_count3),
        .first_err_row (first_err_row3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch a sweep of the default instance from a negedge and check every row,
    // the done slot and the first IDLE cycle. Optionally write the table on the
    // start edge, or attempt a (blocked) write while row 3 is being produced.
    task automatic run_sweep(input logic ch, input logic [7:0] tbl,
                             input bit same_wr, input bit mid_wr, input string tag);
        ch_sel = ch;
        start  = 1'b1;
        if (same_wr) begin
            cfg_we   = 1'b1;
            cfg_ch   = ch;
            cfg_data = tbl;
        end
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        chk({tag, ".busy0"}, busy, 1);
        chk({tag, ".res_clr"}, result, 0);
        chk({tag, ".vld0"}, row_valid, 0);
        for (int r = 0; r < 8; r++) begin
            if (mid_wr && r == 3) begin
                cfg_we   = 1'b1;
                cfg_ch   = ch;
                cfg_data = 8'h00;
            end
            @(negedge clk);
            cfg_we = 1'b0;
            chk($sformatf("%s.r%0d.vld", tag, r), row_valid, 1);
            chk($sformatf("%s.r%0d.in", tag, r), row_in, r);
            chk($sformatf("%s.r%0d.out", tag, r), row_out, tbl[r]);
        end
        @(negedge clk);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".vld_off"}, row_valid, 0);
        chk({tag, ".busy_done"}, busy, 1);
        chk({tag, ".result"}, result, tbl);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".res_hold"}, result, tbl);
    endtask

    initial begin
        int  pulses;
        int  last;
        bit  got_done;
        bit  found;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.vld", row_valid, 0);
        chk("rst.done", done, 0);
        chk("rst.result", result, 0);
        chk("rst.busy3", busy3, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Parity table on channel 0
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_data = 8'h96;
        @(negedge clk);
        cfg_we = 1'b0;
        run_sweep(1'b0, 8'h96, 1'b0, 1'b0, "parity");

        // Majority on channel 1 with a write attempt mid-sweep, then re-sweep
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_data = 8'hE8;
        @(negedge clk);
        cfg_we = 1'b0;
        run_sweep(1'b1, 8'hE8, 1'b0, 1'b1, "maj");
        run_sweep(1'b1, 8'hE8, 1'b0, 1'b0, "maj_again");
        run_sweep(1'b0, 8'h96, 1'b0, 1'b0, "ch0_kept");

        // 3-channel instance: out-of-range start dropped
        cfg_we3 = 1'b1; cfg_ch3 = 2'd2; cfg_data = 8'hE8;
        @(negedge clk);
        cfg_we3 = 1'b0;
        ch_sel3 = 2'd3; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("bad_ch.busy", busy3, 0);
        @(negedge clk);
        chk("bad_ch.busy2", busy3, 0);

        // STEP_CYCLES = 3 sweep of channel 2
        ch_sel3 = 2'd2; start3 = 1'b1;
        @(negedge clk);
        start3   = 1'b0;
        pulses   = 0;
        last     = 0;
        got_done = 1'b0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            @(negedge clk);
            if (row_valid3) begin
                chk($sformatf("step3.p%0d.time", pulses), c, 1 + 3 * pulses);
                chk($sformatf("step3.p%0d.in", pulses), row_in3, pulses);
                pulses++;
                last = c;
            end else if (!done3 && pulses > 0) begin
                chk($sformatf("step3.c%0d.hold", c), row_in3, pulses - 1);
            end
            if (done3) begin
                got_done = 1'b1;
                chk("step3.done_gap", c - last, 3);
            end
        end
        chk("step3.pulses", pulses, 8);
        chk("step3.got_done", got_done, 1);
        chk("step3.result", result3, 8'hE8);

        // Reset in the middle of a sweep, while row 4 is on the outputs
        ch_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (row_valid && row_in == 3'd4) found = 1'b1;
        end
        chk("mid_rst.reached_row4", found, 1);
        chk("mid_rst.partial", result, 8'h16);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.vld", row_valid, 0);
        chk("mid_rst.in", row_in, 0);
        chk("mid_rst.out", row_out, 0);
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.done", done, 0);
        chk("mid_rst.result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.done", done, 0);
        run_sweep(1'b0, 8'h00, 1'b0, 1'b0, "post_rst");

        // Same-edge write with start, then a back-to-back sweep on the first IDLE cycle
        run_sweep(1'b0, 8'h5A, 1'b1, 1'b0, "same_edge");
        run_sweep(1'b0, 8'h0F, 1'b1, 1'b0, "b2b");

`ifdef LUT_SWEEP_CHECK_EN
        exp_vec = 8'h97;
        run_sweep(1'b0, 8'h96, 1'b1, 1'b0, "chk_bad");
        chk("chk_bad.mismatch", mismatch, 1);
        chk("chk_bad.err_count", err_count, 1);
        chk("chk_bad.first_row", first_err_row, 0);
        exp_vec = 8'h96;
        run_sweep(1'b0, 8'h96, 1'b0, 1'b0, "chk_good");
        chk("chk_good.mismatch", mismatch, 0);
        chk("chk_good.err_count", err_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
